// File: rtl/vote_capture_if.sv
// Vote capture bus: start/buttons in, frozen A/B/C result and status out.
// master drives start/btn; slave (the capture block) drives the result side.
interface vote_capture_if;
    logic       start;
    logic [2:0] btn;
    logic       A;
    logic       B;
    logic       C;
    logic       valid;
    logic       busy;
    logic [2:0] voted;

    modport master (
        output start,
        output btn,
        input  A,
        input  B,
        input  C,
        input  valid,
        input  busy,
        input  voted
    );

    modport slave (
        input  start,
        input  btn,
        output A,
        output B,
        output C,
        output valid,
        output busy,
        output voted
    );
endinterface

// File: rtl/vote_capture.sv
// Voter front end: sync + debounce three buttons, run a timed session,
// present a frozen {C,B,A} vote word with valid. Ports: clk, rst_n, bus.
module vote_capture #(
    parameter int DB_CYCLES     = 4,
    parameter int WINDOW_CYCLES = 64,
    parameter int CNT_W         = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    vote_capture_if.slave bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);

    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       db;
    logic [2:0]       db_d;
    logic [CNT_W-1:0] db_cnt [3];
    logic [2:0]       press;

    logic [1:0]       state;
    logic [CNT_W-1:0] win_cnt;
    logic [2:0]       voted;
    logic [2:0]       result;
    logic             valid_q;
    logic             busy_q;
    logic [2:0]       cast;
    logic             finish;

    // Debounced value flips only after DB_CYCLES consecutive mismatches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= bus.btn;
            sync2 <= sync1;
            db_d  <= db;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press  = db & ~db_d;
    // Same-edge press is folded into the final result.
    assign cast   = voted | press;
    assign finish = (voted == 3'b111) || (win_cnt == WIN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            win_cnt <= '0;
            voted   <= '0;
            result  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state   <= S_COLLECT;
                        voted   <= '0;
                        win_cnt <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    win_cnt <= win_cnt + 1'b1;
                    voted   <= cast;
                    if (finish) begin
                        state   <= S_DONE;
                        result  <= cast;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (bus.start) begin
                        state   <= S_COLLECT;
                        voted   <= '0;
                        win_cnt <= '0;
                        result  <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.A     = result[0];
    assign bus.B     = result[1];
    assign bus.C     = result[2];
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.voted = voted;

endmodule

// File: tb/tb_vote_capture.sv
// Directed bench for vote_capture: debounce latency, glitch rejection,
// timeout, early finish, DONE hold, restart and async reset.
module tb_vote_capture;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    vote_capture_if bus ();

    vote_capture dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // {A,B,C,valid,busy}
    function automatic logic [4:0] st();
        return {bus.A, bus.B, bus.C, bus.valid, bus.busy};
    endfunction

    initial begin
        checks    = 0;
        errors    = 0;
        bus.start = 1'b0;
        bus.btn   = 3'b000;
        rst_n     = 1'b0;
        repeat (2) tick();
        check("reset_st", 32'(st()), 32'h0);
        check("reset_voted", 32'(bus.voted), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle", 32'({st(), bus.voted}), 32'h0);
        end

        // Single voter A, window timeout.
        pulse_start();
        check("t2_busy", 32'(st()), 32'b00001);
        bus.btn = 3'b001;
        repeat (6) tick();
        check("t2_voted_pre", 32'(bus.voted), 32'b000);
        tick();
        check("t2_voted_lat", 32'(bus.voted), 32'b001);
        repeat (56) tick();
        check("t2_pre_exp", 32'(st()), 32'b00001);
        tick();
        check("t2_result", 32'(st()), 32'b10010);
        bus.btn = 3'b000;
        repeat (10) tick();

        // Press in DONE is discarded.
        bus.btn = 3'b100;
        repeat (10) tick();
        check("done_hold", 32'(st()), 32'b10010);
        check("done_voted", 32'(bus.voted), 32'b001);
        bus.btn = 3'b000;
        repeat (10) tick();

        // Restart from DONE clears everything.
        pulse_start();
        check("restart_st", 32'(st()), 32'b00001);
        check("restart_voted", 32'(bus.voted), 32'b000);

        // B and C vote, A glitches, start mid-session ignored.
        for (int cyc = 0; cyc < 64; cyc++) begin
            bus.btn[1] = (cyc >= 5 && cyc < 15);
            bus.btn[2] = (cyc >= 10 && cyc < 20);
            bus.btn[0] = (cyc >= 30 && cyc < 32);
            bus.start  = (cyc == 40);
            tick();
            if (cyc < 63) check("t3_no_a", 32'(bus.voted[0]), 32'h0);
            if (cyc == 62) begin
                check("t3_voted", 32'(bus.voted), 32'b110);
                check("t3_busy", 32'(st()), 32'b00001);
            end
        end
        bus.btn   = 3'b000;
        bus.start = 1'b0;
        check("t3_result", 32'(st()), 32'b01110);

        // All three vote: early finish.
        pulse_start();
        bus.btn = 3'b111;
        repeat (6) tick();
        check("t4_pre", 32'(bus.voted), 32'b000);
        tick();
        check("t4_voted", 32'(bus.voted), 32'b111);
        check("t4_still_busy", 32'(st()), 32'b00001);
        tick();
        check("t4_result", 32'(st()), 32'b11110);
        bus.btn = 3'b000;
        repeat (10) tick();

        // Async reset mid-session.
        pulse_start();
        bus.btn = 3'b001;
        repeat (7) tick();
        check("t6_voted", 32'(bus.voted), 32'b001);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async", 32'({st(), bus.voted}), 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("t6_idle", 32'({st(), bus.voted}), 32'h0);

        // Button held through start casts nothing.
        pulse_start();
        check("t6_fresh", 32'({st(), bus.voted}), 32'b00001000);
        repeat (10) tick();
        check("t6_held", 32'(bus.voted), 32'b000);
        bus.btn = 3'b000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vote_capture.md
Name: vote_capture

Overview:
- Upstream front end for the three-input majority circuit.
- Synchronises and debounces three raw voter push-buttons, then runs a timed voting session.
- Delivers a frozen, glitch-free A/B/C vote word with a valid flag; the majority stage evaluates X/Y from it.
- A voter who does not press within the window counts as 0.

Parameters:
- DB_CYCLES, 4, consecutive cycles a synchronised input must differ from its debounced value before that value flips (>=1).
- WINDOW_CYCLES, 64, maximum length of a voting session in clock cycles (>=2).
- CNT_W, 8, width of the debounce and window counters; must hold max(DB_CYCLES, WINDOW_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  synchronous pulse; opens a new voting session.
- btn  in  3  raw asynchronous voter buttons, active-high; bit0=voter A, bit1=B, bit2=C.
- A  out  1  registered vote of voter A to the majority stage.
- B  out  1  registered vote of voter B to the majority stage.
- C  out  1  registered vote of voter C to the majority stage.
- valid  out  1  high while A/B/C hold a completed session result.
- busy  out  1  high while a session is collecting votes.
- voted  out  3  live sticky cast flags of the current session.

Behaviour:
- Reset: rst_n low asynchronously clears all state. State=IDLE; A=B=C=0, valid=0, busy=0, voted=000; sync, debounce and window counters all 0.
- Synchroniser: two flops per btn bit, reset 0.
- Debounce, per bit:
  - Counter increments while the synchronised value differs from the debounced value; it clears when they are equal.
  - On the edge where counter==DB_CYCLES-1 and the values still differ, the debounced value takes the synchronised value and the counter clears.
  - A press pulse is the registered rising edge of the debounced value, one cycle wide.
- Latency: a raw btn rise held stable produces a press pulse, and the voted bit sets, exactly DB_CYCLES+3 rising edges after the rise.
- Glitches shorter than DB_CYCLES synchronised cycles produce no press.
- FSM, three states:
  - IDLE: start=1 -> COLLECT. Clears voted and the window counter; A/B/C/valid unchanged (all 0 after reset).
  - COLLECT:
    - busy=1, valid=0.
    - A press on bit i sets voted[i] (sticky); repeated presses have no effect.
    - Window counter increments every cycle.
    - Leave for DONE on the edge after voted==111 is registered, or on the edge where the window counter==WINDOW_CYCLES-1, whichever comes first.
    - A press arriving on that same final edge is included.
    - start is ignored in COLLECT.
  - DONE:
    - On entry, {C,B,A} <= voted (including any same-edge press); valid=1, busy=0.
    - Outputs hold until the next start.
    - start=1 -> COLLECT: valid drops to 0 on that edge, A/B/C cleared to 0, voted cleared.
- Presses occurring in IDLE or DONE are discarded; they do not pre-load the next session.
- A button held through start does not count; only a new debounced rising edge inside COLLECT casts.
- start and a press on the same edge in IDLE/DONE: session opens, press discarded.
- Reset mid-session: immediate return to IDLE with all outputs 0; no partial result is ever presented with valid=1.
- A/B/C change only on DONE entry or on the start edge leaving DONE, so the downstream majority logic sees no intermediate values.

Test Plan:
- Reset then idle 20 cycles with btn=000 -> A=B=C=0, valid=0, busy=0, voted=000 throughout.
- DB_CYCLES=4. start, then raise btn[0] and hold -> voted=001 exactly 7 edges after the rise. At window expiry (64 cycles after start): A=1, B=0, C=0, valid=1, busy=0.
- start; press btn[1] at cycle 5 and btn[2] at cycle 10, each held 10 cycles; bounce btn[0] high for 2 cycles only -> voted never sets bit0. Result at timeout: A=0, B=1, C=1, valid=1.
- start; press all three buttons -> DONE entered one edge after voted=111, well before cycle 64. Then A=B=C=1, valid=1.
- Complete a session (A=1, B=0, C=0). Press btn[2] while in DONE -> outputs unchanged. Then pulse start -> valid=0, A=B=C=0, voted=000, busy=1.
- start; press btn[0]; assert rst_n=0 mid-session for one cycle, asynchronously -> all outputs 0 immediately, state IDLE. A later start gives a fresh session with voted=000.
